input_conditioner: RTL

Front-end conditioning stage for the board's push-button and slide-switch inputs. It feeds the step-state machine that drives the LEDs. It synchronises the asynchronous pins into `clk`, debounces each one, and produces a one-cycle press pulse for the button. It also generates the periodic `ena` step pulse that paces the state machine. Its outputs give the downstream state machine clean, glitch-free direction inputs, plus a single qualified enable.

---
 rtl/input_conditioner.sv | 86 ++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// Button/switch conditioner: 2-FF sync, per-channel debounce,
// press pulse and free-running step-enable divider.
module input_conditioner #(
  parameter int DEB_CYCLES = 4,
  parameter int TICK_DIV   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pb_n_raw,
  input  logic [1:0] sw_raw,
  output logic       pb_clean,
  output logic       pb_press,
  output logic [1:0] sw_clean,
  output logic       ena
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;
  localparam int TW = $clog2(TICK_DIV) + 1;
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TCK_MAX = TW'(TICK_DIV - 1);

  // channel 0 = button (inverted to active-high), 1..2 = switches
  logic [2:0]    w_raw;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_clean;
  logic [CW-1:0] r_cnt [3];
  logic          r_pb_d;
  logic          r_press;
  logic [TW-1:0] r_tcnt;
  logic          r_ena;

  assign w_raw = {sw_raw, ~pb_n_raw};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_clean <= '0;
      for (int i = 0; i < 3; i++)
        r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_clean[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DEB_MAX) begin
          r_clean[i] <= r_sync2[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pb_d  <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_pb_d  <= r_clean[0];
      r_press <= r_clean[0] & ~r_pb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcnt <= '0;
      r_ena  <= 1'b0;
    end else begin
      r_ena <= (r_tcnt == TCK_MAX);
      if (r_tcnt == TCK_MAX)
        r_tcnt <= '0;
      else
        r_tcnt <= r_tcnt + TW'(1);
    end
  end

  assign pb_clean = r_clean[0];
  assign sw_clean = r_clean[2:1];
  assign pb_press = r_press;
  assign ena      = r_ena;

endmodule
